// File: rtl/mmu_requester.sv
// mmu_requester: initiator side of the memory start/done handshake.
// Moves a block of up to MAX_WORDS words between the memory unit and a flat
// local buffer. It sends one start pulse per word, waits for done, then
// moves on to the next address.
//
// Ports:
//   clock, reset_n      rising-edge clock, async active-low reset
//   cmd_start           one-cycle pulse; accepted only while idle
//   cmd_write           1 = buffer -> memory, 0 = memory -> buffer
//   cmd_base, cmd_len   first address and word count, sampled with cmd_start
//   wr_data             source words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_data             captured read words, same packing
//   busy, done, error   transfer status (error is sticky until next command)
//   mem_*               memory unit handshake and data
module mmu_requester #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_WORDS  = 25,
  parameter int TIMEOUT    = 15
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            cmd_start,
  input  logic                            cmd_write,
  input  logic [ADDR_WIDTH-1:0]           cmd_base,
  input  logic [ADDR_WIDTH-1:0]           cmd_len,
  input  logic [MAX_WORDS*DATA_WIDTH-1:0] wr_data,
  output logic [MAX_WORDS*DATA_WIDTH-1:0] rd_data,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic                            mem_start,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [DATA_WIDTH-1:0]           mem_data_in,
  output logic                            mem_write_enabled,
  input  logic [DATA_WIDTH-1:0]           mem_data_out,
  input  logic                            mem_done
);

  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN   = ADDR_WIDTH'(MAX_WORDS);
  localparam logic [ADDR_WIDTH:0]   ADDR_SPAN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_e;

  typedef logic [MAX_WORDS-1:0][DATA_WIDTH-1:0] words_t;

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  words_t                  rd_q, rd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    start_q, start_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic                    we_q, we_d;

  words_t                  wr_words;
  logic [ADDR_WIDTH:0]     end_addr;
  logic                    cmd_bad;
  logic [IDX_W-1:0]        idx_nxt;
  logic [TMR_W-1:0]        timer_nxt;
  logic                    last_word;

  assign wr_words  = wr_data;
  // One extra bit so base+len == 2^ADDR_WIDTH (ends on the last address) is legal.
  assign end_addr  = {1'b0, cmd_base} + {1'b0, cmd_len};
  assign cmd_bad   = (cmd_len == '0) || (cmd_len > MAX_LEN) || (end_addr > ADDR_SPAN);
  assign idx_nxt   = idx_q + IDX_W'(1);
  assign timer_nxt = timer_q + TMR_W'(1);
  assign last_word = (ADDR_WIDTH'(idx_q) == len_q - ADDR_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    start_d = 1'b0;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    we_d    = we_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          mode_d = cmd_write;
          base_d = cmd_base;
          len_d  = cmd_len;
          idx_d  = '0;
          err_d  = cmd_bad;
          if (cmd_bad) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            busy_d  = 1'b1;
            start_d = 1'b1;
            timer_d = '0;
            addr_d  = cmd_base;
            we_d    = cmd_write;
            wdat_d  = cmd_write ? wr_words[0] : '0;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        timer_d = '0;
      end

      S_WAIT: begin
        timer_d = timer_nxt;
        // mem_done may still be high from the previous access during the
        // first WAIT cycle, so it only counts once timer has moved.
        if (timer_q != '0 && mem_done) begin
          state_d = S_CAPTURE;
          we_d    = 1'b0;
        end else if (timer_nxt == TMR_W'(TIMEOUT)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      S_CAPTURE: begin
        if (!mode_q) rd_d[idx_q] = mem_data_out;
        if (last_word) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_ISSUE;
          idx_d   = idx_nxt;
          start_d = 1'b1;
          timer_d = '0;
          addr_d  = base_q + ADDR_WIDTH'(idx_nxt);
          we_d    = mode_q;
          wdat_d  = mode_q ? wr_words[idx_nxt] : '0;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
    end
  end

  assign rd_data           = rd_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = err_q;
  assign mem_start         = start_q;
  assign mem_address       = addr_q;
  assign mem_data_in       = wdat_q;
  assign mem_write_enabled = we_q;

endmodule
